// File: rtl/time_display_mux_pkg.sv
// Shared constants and types for the 4-digit multiplexed time display.
package time_display_mux_pkg;

    // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // All digit enables inactive (common anode, active-low).
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Digit slot, 0 is the rightmost digit.
    typedef logic [1:0] digit_idx_t;

    // Everything a frame displays, captured once at the start of each frame.
    typedef struct packed {
        logic [3:0] sec_u;
        logic [2:0] sec_t;
        logic [3:0] min_u;
        logic [2:0] min_t;
        logic [3:0] hr_u;
        logic [1:0] hr_t;
        logic       show_seconds;
        logic       adj_min;
        logic       adj_hour;
    } frame_snap_t;

    // Active-low one-hot enable for a single digit slot.
    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/time_display_mux_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD values show a dash.
module bcd_to_seg7
    import time_display_mux_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup, anything above 9 decodes to a dash.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_mux.sv
// Time-multiplexes HH:MM or MM:SS BCD digits onto a 4-digit common-anode display,
// with field blinking for adjustment and a decimal-point colon.
module time_display_mux
    import time_display_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 125,
    parameter int BLANK_LEAD  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] seconds_units,
    input  logic [2:0] seconds_tens,
    input  logic [3:0] minutes_units,
    input  logic [2:0] minutes_tens,
    input  logic [3:0] hours_units,
    input  logic [1:0] hours_tens,
    input  logic       show_seconds,
    input  logic       adj_min,
    input  logic       adj_hour,
    output logic [3:0] anode,
    output logic [6:0] segments,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);

    logic [RW-1:0] refresh_cnt;
    logic          tick;
    digit_idx_t    digit_idx;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_next;
    logic          blink_phase;
    logic          blink_phase_next;
    logic          adj_active;
    logic          frame_start;
    frame_snap_t   live;
    frame_snap_t   snap;
    frame_snap_t   cur;
    logic [3:0]    digit_val;
    logic          in_minutes;
    logic          in_hours;
    logic          lead_blank;
    logic          dp_lit;
    logic          blank;
    logic [6:0]    seg_dec;

    assign tick        = (refresh_cnt == REFRESH_LAST);
    assign frame_start = tick && (digit_idx == 2'd0);
    assign adj_active  = adj_min | adj_hour;

    assign live = '{
        sec_u:        seconds_units,
        sec_t:        seconds_tens,
        min_u:        minutes_units,
        min_t:        minutes_tens,
        hr_u:         hours_units,
        hr_t:         hours_tens,
        show_seconds: show_seconds,
        adj_min:      adj_min,
        adj_hour:     adj_hour
    };

    // The first digit of a frame is decoded from the live inputs being captured,
    // so the whole frame, including slot 0, shows one consistent snapshot.
    assign cur = frame_start ? live : snap;

    // Refresh divider, digit index and frame snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            snap        <= '0;
        end else begin
            if (tick) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx_t'(digit_idx + 2'd1);
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (frame_start) begin
                snap <= live;
            end
        end
    end

    // Blink timebase: counts refresh ticks while a field is being adjusted.
    always_comb begin
        blink_cnt_next   = blink_cnt;
        blink_phase_next = blink_phase;
        if (!adj_active) begin
            blink_cnt_next   = '0;
            blink_phase_next = 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase;
            end else begin
                blink_cnt_next = blink_cnt + 1'b1;
            end
        end
    end

    // Blink state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
        end
    end

    // Select the digit for the current slot and work out field membership and colon.
    always_comb begin
        digit_val  = 4'd0;
        in_minutes = 1'b0;
        in_hours   = 1'b0;
        lead_blank = 1'b0;
        dp_lit     = 1'b0;
        case (digit_idx)
            2'd0: begin
                digit_val  = cur.show_seconds ? cur.sec_u : cur.min_u;
                in_minutes = ~cur.show_seconds;
            end
            2'd1: begin
                digit_val  = cur.show_seconds ? {1'b0, cur.sec_t} : {1'b0, cur.min_t};
                in_minutes = ~cur.show_seconds;
            end
            2'd2: begin
                digit_val  = cur.show_seconds ? cur.min_u : cur.hr_u;
                in_minutes = cur.show_seconds;
                in_hours   = ~cur.show_seconds;
                dp_lit     = cur.show_seconds | ~cur.sec_u[0];
            end
            default: begin
                digit_val  = cur.show_seconds ? {1'b0, cur.min_t} : {2'b00, cur.hr_t};
                in_minutes = cur.show_seconds;
                in_hours   = ~cur.show_seconds;
                lead_blank = (BLANK_LEAD != 0) && !cur.show_seconds && (cur.hr_t == 2'd0);
            end
        endcase
    end

    // Blanking uses the post-tick blink phase so a tick that wraps the blink
    // counter already shows the new phase.
    assign blank = lead_blank
                 | (blink_phase_next & ((in_minutes & cur.adj_min) | (in_hours & cur.adj_hour)));

    bcd_to_seg7 u_dec (
        .bcd (digit_val),
        .seg (seg_dec)
    );

    // Display pin registers: load a new digit on each tick, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode    <= ANODE_OFF;
            segments <= SEG_OFF;
            dp       <= 1'b1;
        end else if (tick) begin
            anode    <= anode_for(digit_idx);
            segments <= blank ? SEG_OFF : seg_dec;
            dp       <= ~dp_lit;
        end
    end

endmodule

// File: doc/time_display_mux.md
Name: time_display_mux

Overview:
- Consumer end of the clock digit interface: takes the BCD digit buses produced by the minutes/hours counter block and time-multiplexes them onto one 4-digit common-anode 7-segment display.
- Shows HH:MM or MM:SS, selected by a mode input.
- Blinks the field currently being adjusted and flashes the decimal point as a colon.
- Sits between the time-keeping counters and the board display pins; runs on the fast board clock, not the 1 Hz seconds clock.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz frame rate); minimum 2.
- BLINK_TICKS, 125, refresh ticks per blink half-period (4 Hz blink at defaults); minimum 1.
- BLANK_LEAD, 1, when 1 a zero hours-tens digit is blanked in HH:MM mode.

Ports:
- clk  input  1  board clock.
- reset  input  1  asynchronous, active-high reset.
- seconds_units  input  4  BCD 0-9.
- seconds_tens  input  3  BCD 0-5.
- minutes_units  input  4  BCD 0-9.
- minutes_tens  input  3  BCD 0-5.
- hours_units  input  4  BCD 0-9.
- hours_tens  input  2  BCD 0-2.
- show_seconds  input  1  0 = HH:MM, 1 = MM:SS.
- adj_min  input  1  blink the minutes field.
- adj_hour  input  1  blink the hours field.
- anode  output  4  active-low digit enables; bit 0 is the rightmost digit.
- segments  output  7  active-low {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.

Behaviour:
- Reset (async, active-high) forces:
  - anode=4'b1111, segments=7'b1111111, dp=1.
  - refresh counter=0, digit index=0, blink counter=0, blink_phase=0 (visible).
  - snapshot registers=0.
- Refresh counter runs 0..REFRESH_DIV-1. The wrap cycle is the tick. Each tick advances the digit index 0→1→2→3→0.
- Snapshot: on the tick where the index wraps 3→0, all six digit inputs and the three mode inputs are captured. The whole frame displays the captured values, so no tearing across a frame.
- Output latency:
  - anode, segments and dp are registered and update together in the cycle after each tick.
  - Between ticks they hold.
  - The first visible digit appears REFRESH_DIV+1 cycles after reset release.
- Digit mapping:
  - HH:MM: idx0 = minutes_units, idx1 = minutes_tens, idx2 = hours_units, idx3 = hours_tens.
  - MM:SS: idx0 = seconds_units, idx1 = seconds_tens, idx2 = minutes_units, idx3 = minutes_tens.
- Decode:
  - Values 0-9 use standard patterns.
  - Any value >9 (e.g. a corrupted tens bus) displays a dash: only g lit, segments=7'b0111111.
  - Narrow tens buses are zero-extended to 4 bits before decode.
- Blanking: the digit's anode bit stays active but segments=7'b1111111 when any of these holds:
  - BLANK_LEAD=1, HH:MM mode, idx3, and the value is 0.
  - blink_phase=1 and the digit belongs to an adjusted field. adj_hour covers idx2/idx3 in HH:MM only. adj_min covers idx0/idx1 in HH:MM and idx2/idx3 in MM:SS.
- Blink: the blink counter counts refresh ticks 0..BLINK_TICKS-1 and toggles blink_phase on wrap. When neither adj input is high, the counter is held at 0 and blink_phase is forced to 0.
- Colon dp: lit only on idx2.
  - HH:MM: lit when the snapshot seconds_units[0]=0, giving a 1 Hz flash.
  - MM:SS: always lit.
- Simultaneous events: a tick and a blink wrap in the same cycle both take effect. The new digit uses the new blink_phase.
- Mode change mid-frame has no effect until the next frame snapshot.
- Reset mid-frame blanks the display immediately, asynchronously.

Decomposition:
- Shared package holds:
  - seg7 pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - digit index type (2 bits).
  - ANODE_OFF constant.
- Sub-module bcd_to_seg7 is purely combinational: 4-bit in, 7-bit active-low out, invalid input gives a dash. It is instantiated once on the muxed digit. The mux block holds all sequential logic.

Test Plan:
- Reset release with REFRESH_DIV=4, inputs 12:34 in HH:MM mode → anode 1110 shows 4 (7'b0011001), then 1101 shows 3, 1011 shows 2 with dp=0 (seconds_units=0), 0111 shows 1. Each digit is held exactly 4 cycles.
- hours_tens=0, hours_units=7, BLANK_LEAD=1 → idx3 segments=7'b1111111 while anode=0111. With BLANK_LEAD=0 it shows 0 (7'b1000000).
- show_seconds=1 with 05:59 MM:SS → digits 9,5,5,0. dp is lit on idx2 every frame. A toggle of show_seconds mid-frame takes effect only at the next idx0.
- adj_min=1 with BLINK_TICKS=8, REFRESH_DIV=4 → idx0/idx1 segments blank for 8 ticks, then visible for 8 ticks. Hour digits are never blanked. Dropping adj_min restores them within one tick.
- minutes_units forced to 4'hC → its digit shows a dash 7'b0111111; other digits are unaffected.
- Assert reset mid-frame → anode=1111, segments=7'b1111111, dp=1 in the same cycle (async). After release, scanning restarts at idx0.
